// File: rtl/alu_pkg.sv
// Shared op-codes and sequencer state for the ALU / multiply-divide unit.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Multi-cycle ops are 10xx: bit 1 selects divide, bit 0 selects signed.
  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
// state | meaning
// IDLE  | waiting for start; hi/lo hold last result
// RUN   | one multiply or divide iteration per cycle, WIDTH iterations
// FIN   | sign correction, hi/lo written, done pulsed on this edge
module muldiv_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e state_q, state_d;
  logic load, iter, fin;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    load = (state_q == IDLE) && start;
    iter = (state_q == RUN);
    fin  = (state_q == FIN);
  end

  assign a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

  assign mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? dvs_q : '0)};
  assign div_shift = {acc_q, mq_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, dvs_q};

  assign prod     = {acc_q, mq_q};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    dvs_d    = dvs_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;
    if (load) begin
      cnt_d    = '0;
      acc_d    = '0;
      mq_d     = a_mag;
      dvs_d    = b_mag;
      is_div_d = op[1];
      sa_d     = op[0] & a[WIDTH-1];
      sb_d     = op[0] & b[WIDTH-1];
      bz_d     = (b == '0);
    end else if (iter) begin
      cnt_d = cnt_q + CW'(1);
      if (is_div_q) begin
        // Restoring step: keep the trial remainder only if it did not go negative.
        if (!div_trial[WIDTH]) begin
          acc_d = div_trial[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_shift[WIDTH-1:0];
          mq_d  = {mq_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
    end else if (fin) begin
      cnt_d  = '0;
      done_d = 1'b1;
      if (is_div_q) begin
        // Divide by zero leaves |a| as remainder, so the dividend sign fix restores a.
        hi_d  = sa_q ? -acc_q : acc_q;
        lo_d  = bz_q ? '1 : ((sa_q ^ sb_q) ? -mq_q : mq_q);
        dbz_d = bz_q;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      dvs_q    <= dvs_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/alu_mdu.sv
// Registered single-cycle ALU with HI/LO moves, fronting the iterative multiply/divide core.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  logic [WIDTH-1:0] result_q, result_d, alu_y;
  logic             sc_done_q;
  logic             accept, md_start, sc_fire, md_done;

  assign accept   = start && !busy;
  assign md_start = accept && is_muldiv(op);
  assign sc_fire  = accept && !is_muldiv(op);

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .reset       (reset),
    .start       (md_start),
    .op          (op[1:0]),
    .a           (a),
    .b           (b),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (md_done),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    alu_y = '0;
    unique case (op)
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_ADD:  alu_y = a + b;
      OP_XOR:  alu_y = a ^ b;
      OP_NOR:  alu_y = ~(a | b);
      OP_SLTU: alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SUB:  alu_y = a - b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: alu_y = hi;
      OP_MFLO: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  assign result_d = sc_fire ? alu_y : result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      sc_done_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      sc_done_q <= sc_fire;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);
  assign done   = sc_done_q | md_done;

endmodule
